// File: rtl/vga_sync_generator.sv
// vga_sync_generator
//   Vertical half of the VGA timing pipeline. Takes the free-running
//   horizontal count and its end-of-line strobe from the upstream pixel
//   counter, tracks the vertical line with a four-phase state machine, and
//   emits registered sync, blanking, pixel coordinates and a frame-start
//   pulse.
//
//   Ports:
//     clk_25MHz         pixel clock (single clock domain)
//     reset             synchronous, active-high
//     H_Count_Value     horizontal count from the upstream counter
//     enable_V_Counter  end-of-line strobe, high alongside H_Count_Value = 0
//     hsync, vsync      sync outputs, active level set by SYNC_POL
//     video_on          output pixel is visible
//     pixel_x, pixel_y  visible pixel coordinates, 0 while blanked
//     frame_start       one-cycle pulse with pixel (0,0)
//     V_Count_Value     current vertical line
//     frame_count       frame counter
//
//   Build option:
//     VGA_FRAME_COUNT_EN  when defined, frame_count counts frame_start
//                         pulses (wrapping at 255); otherwise it is tied to 0.
module vga_sync_generator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic [15:0] H_Count_Value,
  input  logic        enable_V_Counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [15:0] V_Count_Value,
  output logic [7:0]  frame_count
);

  localparam logic [15:0] H_VIS_END = 16'(H_ACTIVE);
  localparam logic [15:0] HS_BEG    = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_TOT     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);

  localparam logic [15:0] V_VIS_END = 16'(V_ACTIVE);
  localparam logic [15:0] VS_BEG    = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST    = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [1:0] V_ACT = 2'd0;
  localparam logic [1:0] V_FPO = 2'd1;
  localparam logic [1:0] V_SYN = 2'd2;
  localparam logic [1:0] V_BPO = 2'd3;

  logic [1:0]  v_state;
  logic [1:0]  v_state_nxt;
  logic [15:0] v_next;
  logic [15:0] v_eff;
  logic        h_vis;
  logic        h_sync_act;
  logic        vid_d;
  logic        fs_d;

  // Decode runs on the line the pixel belongs to: in the strobe cycle that is
  // already the next line, so h=0 is the first pixel of the new line.
  // v_state_nxt doubles as the state for v_eff, which drives vsync.
  always_comb begin
    v_next      = (V_Count_Value == V_LAST) ? '0 : V_Count_Value + 16'd1;
    v_eff       = enable_V_Counter ? v_next : V_Count_Value;
    v_state_nxt = v_state;
    if (enable_V_Counter) begin
      case (v_state)
        V_ACT: if (v_eff == V_VIS_END) v_state_nxt = V_FPO;
        V_FPO: if (v_eff == VS_BEG)    v_state_nxt = V_SYN;
        V_SYN: if (v_eff == VS_END)    v_state_nxt = V_BPO;
        V_BPO: if (v_eff == '0)        v_state_nxt = V_ACT;
      endcase
    end
    h_vis      = H_Count_Value < H_VIS_END;
    h_sync_act = (H_Count_Value >= HS_BEG) && (H_Count_Value < HS_END) &&
                 (H_Count_Value < H_TOT);
    vid_d      = h_vis && (v_eff < V_VIS_END);
    fs_d       = vid_d && (H_Count_Value == '0) && (v_eff == '0);
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      V_Count_Value <= V_LAST;
      v_state       <= V_BPO;
      hsync         <= ~SYNC_POL;
      vsync         <= ~SYNC_POL;
      video_on      <= 1'b0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      frame_start   <= 1'b0;
    end else begin
      if (enable_V_Counter) V_Count_Value <= v_next;
      v_state     <= v_state_nxt;
      hsync       <= h_sync_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_state_nxt == V_SYN) ? SYNC_POL : ~SYNC_POL;
      video_on    <= vid_d;
      pixel_x     <= vid_d ? H_Count_Value[9:0] : '0;
      pixel_y     <= vid_d ? v_eff[9:0] : '0;
      frame_start <= fs_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk_25MHz) begin
    if (reset)            frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 8'd1;
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
module tb_vga_sync_generator;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic [15:0] H_Count_Value;
  logic        enable_V_Counter;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
  logic [15:0] V_Count_Value;
  logic [7:0]  frame_count;

  int checks   = 0;
  int failures = 0;
  int hs_low, vs_low, vid_hi, fs_cnt;

  vga_sync_generator dut (
    .clk_25MHz       (clk_25MHz),
    .reset           (reset),
    .H_Count_Value   (H_Count_Value),
    .enable_V_Counter(enable_V_Counter),
    .hsync           (hsync),
    .vsync           (vsync),
    .video_on        (video_on),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .frame_start     (frame_start),
    .V_Count_Value   (V_Count_Value),
    .frame_count     (frame_count)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge that registered them.
  task automatic step(input logic [15:0] h, input logic en);
    @(negedge clk_25MHz);
    H_Count_Value    = h;
    enable_V_Counter = en;
    @(posedge clk_25MHz);
    #1;
    if (hsync == 1'b0) hs_low++;
    if (vsync == 1'b0) vs_low++;
    if (video_on)      vid_hi++;
    if (frame_start)   fs_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    hs_low = 0; vs_low = 0; vid_hi = 0; fs_cnt = 0;
  endtask

  task automatic full_line();
    for (int h = 0; h < 800; h++) step(16'(h), h == 0);
  endtask

  function automatic logic [7:0] fc_exp(input logic [7:0] v);
`ifdef VGA_FRAME_COUNT_EN
    return v;
`else
    return v & 8'h00;
`endif
  endfunction

  initial begin
    reset = 1'b1; H_Count_Value = '0; enable_V_Counter = 1'b0;
    clear_counts();
    step(0, 0);
    step(0, 0);
    check("rst_v",      V_Count_Value, 524);
    check("rst_hsync",  hsync, 1);
    check("rst_vsync",  vsync, 1);
    check("rst_vid",    video_on, 0);
    check("rst_px",     pixel_x, 0);
    check("rst_py",     pixel_y, 0);
    check("rst_fs",     frame_start, 0);
    check("rst_fc",     frame_count, 0);
    check("rst_state",  dut.v_state, 3);

    reset = 1'b0;
    step(799, 0);
    check("pre_v",   V_Count_Value, 524);
    check("pre_vid", video_on, 0);

    // Line 0, full 800 pixels
    clear_counts();
    for (int h = 0; h < 800; h++) begin
      step(16'(h), h == 0);
      if (h == 0) begin
        check("l0_v",   V_Count_Value, 0);
        check("l0_vid", video_on, 1);
        check("l0_px",  pixel_x, 0);
        check("l0_py",  pixel_y, 0);
        check("l0_fs",  frame_start, 1);
      end
      if (h == 1)   begin check("h1_fs", frame_start, 0); check("h1_px", pixel_x, 1); end
      if (h == 639) begin check("h639_px", pixel_x, 639); check("h639_vid", video_on, 1); end
      if (h == 640) begin check("h640_px", pixel_x, 0); check("h640_vid", video_on, 0); end
      if (h == 655) check("h655_hs", hsync, 1);
      if (h == 656) check("h656_hs", hsync, 0);
      if (h == 751) check("h751_hs", hsync, 0);
      if (h == 752) check("h752_hs", hsync, 1);
    end
    check("line_hs_low", hs_low, 96);
    check("line_vid_hi", vid_hi, 640);
    check("line_fs_cnt", fs_cnt, 1);

    // Compressed lines: one strobe per line
    for (int i = 1; i <= 479; i++) step(0, 1);
    check("l479_v",     V_Count_Value, 479);
    check("l479_py",    pixel_y, 479);
    check("l479_vid",   video_on, 1);
    check("l479_state", dut.v_state, 0);
    step(0, 1);
    check("l480_v",     V_Count_Value, 480);
    check("l480_vid",   video_on, 0);
    check("l480_py",    pixel_y, 0);
    check("l480_state", dut.v_state, 1);
    check("l480_vs",    vsync, 1);
    for (int i = 481; i <= 489; i++) step(0, 1);
    check("l489_v",  V_Count_Value, 489);
    check("l489_vs", vsync, 1);

    // Lines 490..492 in full: vsync low for exactly lines 490 and 491
    clear_counts();
    full_line();
    check("l490_state", dut.v_state, 2);
    full_line();
    full_line();
    check("vs_low",      vs_low, 1600);
    check("vs_hs_low",   hs_low, 288);
    check("vs_vid_hi",   vid_hi, 0);
    check("l492_state",  dut.v_state, 3);
    check("l492_vs",     vsync, 1);

    clear_counts();
    for (int i = 493; i <= 524; i++) step(0, 1);
    check("blank_vid_hi", vid_hi, 0);
    check("l524_v",       V_Count_Value, 524);
    step(0, 1);
    check("wrap_v",     V_Count_Value, 0);
    check("wrap_fs",    frame_start, 1);
    check("wrap_vid",   video_on, 1);
    check("wrap_state", dut.v_state, 0);

    // Reset at line 300, h=400
    for (int i = 1; i <= 300; i++) step(0, 1);
    step(400, 0);
    check("l300_v",  V_Count_Value, 300);
    check("l300_px", pixel_x, 400);
    check("l300_py", pixel_y, 300);
    reset = 1'b1;
    step(401, 0);
    check("mrst_v",     V_Count_Value, 524);
    check("mrst_hs",    hsync, 1);
    check("mrst_vs",    vsync, 1);
    check("mrst_vid",   video_on, 0);
    check("mrst_px",    pixel_x, 0);
    check("mrst_py",    pixel_y, 0);
    check("mrst_state", dut.v_state, 3);
    step(0, 1);
    check("rst_prio_v",  V_Count_Value, 524);
    check("rst_prio_fs", frame_start, 0);
    reset = 1'b0;
    step(1, 0);
    check("post_rst_v",   V_Count_Value, 524);
    check("post_rst_vid", video_on, 0);
    step(0, 1);
    check("post_rst_l0_v",  V_Count_Value, 0);
    check("post_rst_l0_fs", frame_start, 1);

    // Strobe with h != 0 still advances the line
    step(5, 1);
    check("odd_strobe_v",  V_Count_Value, 1);
    check("odd_strobe_px", pixel_x, 5);
    check("odd_strobe_py", pixel_y, 1);
    check("odd_strobe_fs", frame_start, 0);

    // Out-of-range horizontal counts
    step(900, 0);
    check("h900_hs",  hsync, 1);
    check("h900_vid", video_on, 0);
    check("h900_px",  pixel_x, 0);
    check("h900_py",  pixel_y, 0);
    check("h900_v",   V_Count_Value, 1);
    step(700, 0);
    check("h700_hs", hsync, 0);
    step(16'hFFFF, 0);
    check("hmax_hs",  hsync, 1);
    check("hmax_vid", video_on, 0);

    // Frame counter: holding h=0 on line 0 raises frame_start every cycle
    reset = 1'b1;
    step(0, 0);
    check("fc_rst", frame_count, 0);
    reset = 1'b0;
    step(0, 1);
    check("fc_fs0", frame_start, 1);
    check("fc_0",   frame_count, 0);
    clear_counts();
    for (int i = 1; i <= 255; i++) step(0, 0);
    check("fc_hold_fs", fs_cnt, 255);
    check("fc_255",     frame_count, fc_exp(8'd255));
    step(0, 0);
    check("fc_wrap0",   frame_count, fc_exp(8'd0));
    step(0, 0);
    check("fc_wrap1",   frame_count, fc_exp(8'd1));
    step(1, 0);
    check("fc_last_fs", frame_start, 0);
    check("fc_2",       frame_count, fc_exp(8'd2));
    step(1, 0);
    check("fc_hold2",   frame_count, fc_exp(8'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Downstream stage of the horizontal pixel counter in the VGA pipeline. Consumes the free-running horizontal count and its end-of-line strobe, and maintains the vertical line counter with a four-phase vertical state machine. Produces registered hsync/vsync, the active-video flag, pixel coordinates and a frame-start pulse for the cube renderer and pixel mux.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = sum = 800, and the upstream counter's H_MAX must equal H_TOTAL-1
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = sum = 525
- SYNC_POL, 0, active level of hsync and vsync (0 = active-low)
- clk_25MHz  input  1  pixel clock; the single clock of the block
- reset  input  1  synchronous, active-high reset
- H_Count_Value  input  16  horizontal count from the upstream counter
- enable_V_Counter  input  1  end-of-line strobe; high in the same cycle that H_Count_Value = 0
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while the output pixel is visible
- pixel_x  output  10  column of the visible pixel; 0 when not visible
- pixel_y  output  10  row of the visible pixel; 0 when not visible
- frame_start  output  1  one-cycle pulse accompanying pixel (0,0)
- V_Count_Value  output  16  current vertical line, 0..V_TOTAL-1
- frame_count  output  8  frame counter (see Configuration)

## Operation
- **Vertical counter.** On each cycle with enable_V_Counter=1, V_Count_Value advances by 1. At V_TOTAL-1 it wraps to 0. Otherwise it holds.
- **Effective line.** Decode uses v_eff = next(V_Count_Value) when enable_V_Counter=1, and V_Count_Value otherwise. This makes the H=0 pixel belong to the new line.
- **Vertical FSM states.**
  - V_ACT covers lines 0..V_ACTIVE-1.
  - V_FPO covers the next V_FP lines.
  - V_SYN covers the next V_SYNC lines.
  - V_BPO covers the remaining lines.
- **FSM transitions.** Transitions occur only on enable_V_Counter, when v_eff crosses the boundary: V_ACT→V_FPO at 480, V_FPO→V_SYN at 490, V_SYN→V_BPO at 492, V_BPO→V_ACT at 0. The state always equals the decode of V_Count_Value; the bench checks this.
- **Horizontal decode.** Let h = H_Count_Value.
  - Visible when h < H_ACTIVE.
  - hsync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - When h ≥ H_TOTAL, the pixel is treated as blanking with hsync inactive.
- **Output decode.**
  - vsync is active while the state for v_eff is V_SYN (lines 490..491).
  - video_on = (h visible) AND (v_eff < V_ACTIVE).
  - pixel_x = h[9:0] and pixel_y = v_eff[9:0] when video_on; both are 0 otherwise.
  - frame_start = video_on AND h=0 AND v_eff=0.
- **Unchecked strobe.** enable_V_Counter is trusted; it advances the line even if h≠0.

## Timing
- hsync, vsync, video_on, pixel_x, pixel_y and frame_start are registered: 1-cycle latency from H_Count_Value and enable_V_Counter.
- V_Count_Value updates on the edge ending the strobe cycle.
- **Reset values.**
  - V_Count_Value = V_TOTAL-1 (524) and state = V_BPO, so the first strobe after reset starts line 0.
  - hsync = vsync = inactive level (1 for SYNC_POL=0).
  - video_on = 0, pixel_x = pixel_y = 0, frame_start = 0, frame_count = 0.
- reset has priority over the strobe in the same cycle.
- Reset mid-frame returns all state to the reset values on the next edge. The upstream counter is not reset, so alignment resumes at its next strobe.
- **Wrap.** At line 524 with a strobe, the next line is 0. frame_start is asserted 1 cycle later, coincident with pixel (0,0).

## Configuration
- VGA_FRAME_COUNT_EN defined:
  - frame_count increments by 1 on each cycle where frame_start is high.
  - It wraps 255→0 and resets to 0.
  - The cube renderer uses it as the rotation phase.
- Not defined:
  - frame_count is tied to 0.
  - No counter logic is instantiated.

## Test plan
- Reset, then drive the upstream counter free-running (H_MAX=799) → the first strobe sets V_Count_Value=0. One cycle after h=0, video_on=1, pixel=(0,0), and frame_start pulses for exactly 1 cycle.
- Single line → hsync is low exactly 96 cycles, output-aligned to inputs h=656..751. video_on is high for 640 cycles. pixel_x runs 0..639, then returns to 0.
- Full frame → vsync is low for exactly 2 lines (1600 cycles) at lines 490..491. video_on is never high on lines 480..524. There are exactly 420000 cycles between frame_start pulses.
- Assert reset at line 300, h=400 → the next edge gives V_Count_Value=524 and all outputs at reset values. The next strobe gives line 0 and a frame_start pulse.
- Drive h=900 with no strobe → hsync inactive, video_on=0, pixels 0.
- With VGA_FRAME_COUNT_EN, run 257 frames → frame_count=1 after wrap. Without the macro → frame_count stays 0.
